// File: rtl/cordic_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_arbiter : round-robin arbiter/sequencer sharing one iterative CORDIC
//                  cosine core among 2**IDW requesters.
// Optional feature macro: CORDIC_ARB_TIMEOUT_EN (BUSY watchdog, TMO cycles).
// Revision: 1.0
// ----------------------------------------------------------------------------
module cordic_arbiter #(
  parameter int IDW = 2,
  parameter int TMO = 63
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [(2**IDW)-1:0]    req,
  input  logic [16*(2**IDW)-1:0] theta_in,
  output logic [(2**IDW)-1:0]    gnt,
  output logic                   core_bgn,
  output logic [15:0]            core_theta,
  input  logic                   core_fin,
  input  logic [15:0]            core_cos,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [IDW-1:0]         rsp_id,
  output logic [15:0]            rsp_cos,
  output logic                   rsp_err,
  output logic                   busy
);
  localparam int NREQ = 2**IDW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [15:0]     core_theta_q, core_theta_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_cos_q, rsp_cos_d;
  logic            fin_low_seen_q, fin_low_seen_d;

  logic            win_vld;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  cand;
  logic [15:0]     win_theta;
  logic            fin_done;

  // Search upward from ptr; the IDW-bit add wraps NREQ-1 back to 0.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + IDW'(k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign win_theta = theta_in[{win_id, 4'b0000} +: 16];

  // A fin still high from the previous job must drop before it counts.
  assign fin_done = core_fin && fin_low_seen_q;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rsp_err_q, rsp_err_d;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt_q == CW'(TMO - 1));
  assign rsp_err = rsp_err_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = ^TMO;
  assign rsp_err    = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_d          = '0;
    core_theta_d   = core_theta_q;
    rsp_vld_d      = rsp_vld_q;
    rsp_id_d       = rsp_id_q;
    rsp_cos_d      = rsp_cos_q;
    fin_low_seen_d = fin_low_seen_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    rsp_err_d      = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          core_theta_d = win_theta;
          rsp_id_d     = win_id;
          gnt_d        = NREQ'(1) << win_id;
          ptr_d        = win_id + IDW'(1);
          state_d      = START;
        end
      end
      START: begin
        fin_low_seen_d = 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
        tmo_cnt_d      = '0;
`endif
        state_d        = BUSY;
      end
      BUSY: begin
        if (!core_fin) begin
          fin_low_seen_d = 1'b1;
        end
        if (fin_done) begin
          rsp_cos_d = core_cos;
          rsp_vld_d = 1'b1;
`ifdef CORDIC_ARB_TIMEOUT_EN
          rsp_err_d = 1'b0;
`endif
          state_d   = RESP;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_cos_d = 16'h0000;
          rsp_err_d = 1'b1;
          rsp_vld_d = 1'b1;
          state_d   = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      gnt_q          <= '0;
      core_theta_q   <= '0;
      rsp_vld_q      <= 1'b0;
      rsp_id_q       <= '0;
      rsp_cos_q      <= '0;
      fin_low_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_q          <= gnt_d;
      core_theta_q   <= core_theta_d;
      rsp_vld_q      <= rsp_vld_d;
      rsp_id_q       <= rsp_id_d;
      rsp_cos_q      <= rsp_cos_d;
      fin_low_seen_q <= fin_low_seen_d;
    end
  end

  assign gnt        = gnt_q;
  assign core_bgn   = (state_q == START);
  assign core_theta = core_theta_q;
  assign rsp_vld    = rsp_vld_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_cos    = rsp_cos_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cordic_arbiter : randomized traffic with a round-robin reference model,
//                     a behavioural CORDIC core model and a response scoreboard.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_cordic_arbiter;
  localparam int IDW  = 2;
  localparam int NREQ = 4;
  localparam int TMO  = 63;

  logic                 clk      = 1'b0;
  logic                 rst_b    = 1'b0;
  logic [NREQ-1:0]      req      = '0;
  logic [15:0]          theta [NREQ];
  logic [16*NREQ-1:0]   theta_in;
  logic [NREQ-1:0]      gnt;
  logic                 core_bgn;
  logic [15:0]          core_theta;
  logic                 core_fin = 1'b0;
  logic [15:0]          core_cos = '0;
  logic                 rsp_vld;
  logic                 rsp_rdy  = 1'b1;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          rsp_cos;
  logic                 rsp_err;
  logic                 busy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_theta
    assign theta_in[16*g +: 16] = theta[g];
  end

  cordic_arbiter #(.IDW(IDW), .TMO(TMO)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req        (req),
    .theta_in   (theta_in),
    .gnt        (gnt),
    .core_bgn   (core_bgn),
    .core_theta (core_theta),
    .core_fin   (core_fin),
    .core_cos   (core_cos),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_id     (rsp_id),
    .rsp_cos    (rsp_cos),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    cos;
    logic           err;
  } exp_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q [$];

  // Control knobs written by the stimulus process only.
  bit   chk_en = 0;
  bit   core_en = 1;
  bit   fin_man = 0;
  bit   stuck = 0;
  int   fix_lat = 0;
  int   fix_fall = 0;
  bit   rand_req = 0;
  int   keep_mode = 1;      // 0 random, 1 drop on grant, 2 keep
  bit   rdy_rand = 0;
  bit   rdy_fixed = 1;
  int   flush_cnt = 0;

  // Model state written by the monitor only.
  int   m_ptr = 0;
  bit   m_inflight = 0;
  int   hs_cyc = -100;
  int   n_gnt = 0;
  int   n_rsp = 0;
  int   flush_seen = 0;

  // Written by the core model only.
  int   exp_rsp_cyc = -1;

  logic [NREQ-1:0] req_s;
  logic [15:0]     theta_s [NREQ];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    req_s <= req;
    for (int i = 0; i < NREQ; i++) theta_s[i] <= theta[i];
  end

  function automatic logic [15:0] cos_model(input logic [15:0] t);
    return (t * 16'd3) ^ 16'h5A5A;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},        32'(gnt),        0);
    check({tag, "_core_bgn"},   32'(core_bgn),   0);
    check({tag, "_core_theta"}, 32'(core_theta), 0);
    check({tag, "_rsp_vld"},    32'(rsp_vld),    0);
    check({tag, "_rsp_id"},     32'(rsp_id),     0);
    check({tag, "_rsp_cos"},    32'(rsp_cos),    0);
    check({tag, "_rsp_err"},    32'(rsp_err),    0);
    check({tag, "_busy"},       32'(busy),       0);
  endtask

  // Core model: fin drops fall cycles after bgn (if still high), rises lat cycles after bgn.
  initial begin
    int lat, fall, t0;
    bit pend;
    lat = 0; fall = 0; t0 = 0; pend = 0;
    forever begin
      @(posedge clk); #1;
      if (!core_en) begin
        core_fin = fin_man;
        pend = 0;
        continue;
      end
      if (!rst_b) begin
        pend = 0;
        continue;
      end
      if (core_bgn) begin
        lat  = (fix_lat != 0) ? fix_lat : int'($urandom_range(3, 20));
        fall = core_fin ? ((fix_fall != 0) ? fix_fall : int'($urandom_range(1, lat - 1))) : 0;
        t0   = cyc;
        if (stuck) begin
          core_fin = 1'b0;
          pend = 0;
`ifdef CORDIC_ARB_TIMEOUT_EN
          exp_rsp_cyc = cyc + TMO + 1;
`else
          exp_rsp_cyc = -1;
`endif
        end else begin
          pend = 1;
          exp_rsp_cyc = cyc + lat + 1;
        end
      end else if (pend) begin
        if (cyc == t0 + fall) core_fin = 1'b0;
        if (cyc == t0 + lat) begin
          core_fin = 1'b1;
          core_cos = cos_model(core_theta);
          pend = 0;
        end
      end
    end
  end

  // Monitor: predicts grants from the round-robin model, scores responses.
  initial begin
    bit            prev_vld, prev_rdy, expect_g;
    logic [IDW-1:0] h_id;
    logic [15:0]   h_cos;
    logic          h_err;
    exp_t          e;
    int            w;
    prev_vld = 0; prev_rdy = 0; h_id = '0; h_cos = '0; h_err = 1'b0;
    forever begin
      @(negedge clk);
      if (flush_cnt != flush_seen) begin
        flush_seen = flush_cnt;
        exp_q.delete();
        m_ptr = 0;
        m_inflight = 0;
        hs_cyc = -100;
      end
      if (!chk_en) begin
        prev_vld = 0;
        continue;
      end
      expect_g = !m_inflight && (cyc >= hs_cyc + 2) && (req_s != '0);
      if (gnt != '0 || expect_g) begin
        w = rr_pick(req_s, m_ptr);
        check("gnt_rr", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
        check("gnt_while_busy", 32'(m_inflight), 0);
        check("core_bgn_with_gnt", 32'(core_bgn), 1);
        if (w >= 0) begin
          check("core_theta", 32'(core_theta), 32'(theta_s[w]));
          e.id = IDW'(w);
`ifdef CORDIC_ARB_TIMEOUT_EN
          e.cos = stuck ? 16'h0000 : cos_model(theta_s[w]);
          e.err = stuck;
`else
          e.cos = cos_model(theta_s[w]);
          e.err = 1'b0;
`endif
          exp_q.push_back(e);
          m_ptr = (w + 1) % NREQ;
        end
        m_inflight = 1;
        n_gnt++;
      end else begin
        check("core_bgn_idle", 32'(core_bgn), 0);
      end
      check("busy", 32'(busy), 32'(m_inflight));
      if (rsp_vld) begin
        if (!prev_vld || prev_rdy) begin
          n_rsp++;
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_vld), 0);
          end else begin
            check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
            check("rsp_cos", 32'(rsp_cos), 32'(exp_q[0].cos));
            check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
            check("rsp_latency", 32'(cyc), 32'(exp_rsp_cyc));
          end
          h_id = rsp_id; h_cos = rsp_cos; h_err = rsp_err;
        end else begin
          check("hold_id", 32'(rsp_id), 32'(h_id));
          check("hold_cos", 32'(rsp_cos), 32'(h_cos));
          check("hold_err", 32'(rsp_err), 32'(h_err));
        end
        if (rsp_rdy) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_inflight = 0;
          hs_cyc = cyc;
        end
      end else if (prev_vld && !prev_rdy) begin
        check("rsp_vld_held", 32'(rsp_vld), 1);
      end
      prev_vld = rsp_vld;
      prev_rdy = rsp_rdy;
    end
  end

  // One stimulus cycle: requesters hold req/angle until granted.
  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && gnt[i]) begin
        if (keep_mode == 1 || (keep_mode == 0 && $urandom_range(0, 1) == 0)) req[i] = 1'b0;
        theta[i] = 16'($urandom);
      end else if (!req[i] && rand_req && $urandom_range(0, 3) == 0) begin
        req[i]   = 1'b1;
        theta[i] = 16'($urandom);
      end
    end
    rsp_rdy = rdy_rand ? ($urandom_range(0, 9) < 7) : rdy_fixed;
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((req != '0 || busy || m_inflight) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: req=%0h busy=%0d after %0d cycles", name, req, busy, limit);
    end
  endtask

  initial begin
    int base, n;
    for (int i = 0; i < NREQ; i++) theta[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_b = 1'b1;
    chk_en = 1;

    // All four requesting continuously: grants 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) theta[i] = 16'($urandom);
    keep_mode = 2;
    req = 4'b1111;
    base = n_gnt;
    n = 0;
    while (n_gnt < base + 5 && n < 500) begin step(); n++; end
    check("rr_five_grants", 32'(n_gnt >= base + 5), 1);
    keep_mode = 1;
    drain("rr", 500);

    // Single requester 2, fixed 16-cycle core, stale fin dropping after 2.
    fix_lat = 16;
    fix_fall = 2;
    theta[2] = 16'h1000;
    req = 4'b0100;
    drain("single", 200);
    fix_lat = 0;
    fix_fall = 0;

    // Backpressure with requesters 0 and 1 pending.
    theta[0] = 16'($urandom);
    theta[1] = 16'($urandom);
    rdy_fixed = 0;
    req = 4'b0011;
    n = 0;
    while (!rsp_vld && n < 200) begin step(); n++; end
    check("bp_rsp_seen", 32'(rsp_vld), 1);
    repeat (5) step();
    rdy_fixed = 1;
    drain("bp", 500);

    // Random traffic and random backpressure.
    rand_req = 1;
    keep_mode = 0;
    rdy_rand = 1;
    repeat (3000) step();
    rand_req = 0;
    keep_mode = 1;
    rdy_rand = 0;
    drain("random", 2000);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    // Core never finishes.
    stuck = 1;
    base = n_rsp;
    req = 4'b0001;
    repeat (80) step();
`ifdef CORDIC_ARB_TIMEOUT_EN
    check("timeout_rsp_count", 32'(n_rsp - base), 1);
    req = 4'b1000;
    repeat (10) step();
`else
    check("stuck_no_rsp", 32'(n_rsp - base), 0);
`endif
    check("stuck_busy", 32'(busy), 1);

    // Reset in the middle of BUSY.
    @(negedge clk);
    chk_en = 0;
    #1 rst_b = 1'b0;
    #1 check_zero("async_reset");
    req = '0;
    core_en = 0;
    fin_man = 0;
    stuck = 0;
    flush_cnt++;
    repeat (3) step();
    @(negedge clk);
    rst_b = 1'b1;
    check_zero("post_reset");
    for (int k = 0; k < 8; k++) begin
      fin_man = (k >= 2 && k < 4);
      step();
      @(negedge clk);
      check("late_fin_no_vld", 32'(rsp_vld), 0);
      check("late_fin_idle", 32'(busy), 0);
    end
    core_en = 1;
    chk_en = 1;

    // Pointer restarts at 0 after reset.
    for (int i = 0; i < NREQ; i++) theta[i] = 16'($urandom);
    req = 4'b1111;
    drain("post_reset_rr", 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
